// File: rtl/bru_pkg.sv
// Shared definitions for branch_resolve_unit.
// Holds the funct3 encodings of the six conditional branches, the request and result
// records carried through the pipeline, and the helper that turns a compared request
// into a resolved result (target, fall-through, redirect and mispredict).
// Records are sized by BRU_XLEN. The top-level XLEN parameter must match it.
package bru_pkg;
  localparam int BRU_XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [2:0]          funct3;
    logic [BRU_XLEN-1:0] rs1;
    logic [BRU_XLEN-1:0] rs2;
    logic [BRU_XLEN-1:0] pc;
    logic [BRU_XLEN-1:0] imm;
    logic                pred_taken;
    logic [BRU_XLEN-1:0] pred_pc;
  } bru_req_t;

  typedef struct packed {
    logic                taken;
    logic [BRU_XLEN-1:0] target;
    logic                mispredict;
    logic [BRU_XLEN-1:0] redirect_pc;
    logic                illegal;
  } bru_res_t;

  // Sums wrap at BRU_XLEN bits. Mispredict compares the true next PC with the PC
  // fetch actually steered to, so the predicted direction alone is not consulted.
  function automatic bru_res_t bru_resolve(input bru_req_t r, input logic taken,
                                           input logic illegal);
    bru_res_t res;
    res.taken       = taken;
    res.illegal     = illegal;
    res.target      = r.pc + r.imm;
    res.redirect_pc = taken ? res.target : r.pc + BRU_XLEN'(4);
    res.mispredict  = (res.redirect_pc != r.pred_pc);
    return res;
  endfunction
endpackage

// File: rtl/bru_if.sv
// Request/result bus of branch_resolve_unit.
// slave  : the unit's view (takes in_*, drives in_ready and out_*).
// master : the execute/fetch side's view.
interface bru_if #(parameter int XLEN = 32) ();
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pred_pc;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic            out_mispredict;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, in_pred_pc,
    input  out_ready,
    output in_ready,
    output out_valid, out_taken, out_target, out_mispredict, out_redirect_pc, out_illegal
  );

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, in_pred_pc,
    output out_ready,
    input  in_ready,
    input  out_valid, out_taken, out_target, out_mispredict, out_redirect_pc, out_illegal
  );
endinterface

// File: rtl/bru_compare.sv
// Combinational branch condition evaluation.
// Ports: funct3, rs1, rs2 in; taken, illegal out.
// BLT/BGE compare signed, BLTU/BGEU unsigned. funct3 010/011 flag illegal and never take.
module bru_compare
  import bru_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined RV32I conditional branch resolution.
// Ports: clk, rst_n (synchronous, active low), flush, bus (bru_if.slave: in_* request
// with valid/ready, out_* registered result with valid/ready).
// STAGES=1: compare and resolve feed the output register directly.
// STAGES=2: compare result is registered, resolve math runs in the second stage.
// The whole pipe advances together whenever the output register is empty or drained.
// Optional: `define BRU_PERF_CNT_EN adds saturating perf_branches/perf_taken/
// perf_mispredicts counters over accepted output transfers.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN   = BRU_XLEN,
  parameter int STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  bru_if.slave        bus
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_taken,
  output logic [31:0] perf_mispredicts
`endif
);
  bru_req_t in_req;
  logic     in_taken, in_illegal;

  assign in_req = '{funct3:     bus.in_funct3,
                    rs1:        bus.in_rs1,
                    rs2:        bus.in_rs2,
                    pc:         bus.in_pc,
                    imm:        bus.in_imm,
                    pred_taken: bus.in_pred_taken,
                    pred_pc:    bus.in_pred_pc};

  bru_compare #(.XLEN(XLEN)) u_cmp (
    .funct3  (in_req.funct3),
    .rs1     (in_req.rs1),
    .rs2     (in_req.rs2),
    .taken   (in_taken),
    .illegal (in_illegal)
  );

  logic     out_vld;
  bru_res_t out_res;
  logic     adv;

  assign adv         = !out_vld | bus.out_ready;
  assign bus.in_ready = adv;

  // Resolve-stage view: a register in the 2-stage build, a wire in the 1-stage build.
  logic     rs_vld, rs_taken, rs_illegal;
  bru_req_t rs_req;

  generate
    if (STAGES == 2) begin : g_s2
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rs_vld     <= 1'b0;
          rs_req     <= '0;
          rs_taken   <= 1'b0;
          rs_illegal <= 1'b0;
        end else if (flush) begin
          rs_vld <= 1'b0;
        end else if (adv) begin
          rs_vld <= bus.in_valid;
          if (bus.in_valid) begin
            rs_req     <= in_req;
            rs_taken   <= in_taken;
            rs_illegal <= in_illegal;
          end
        end
      end
    end else begin : g_s1
      assign rs_vld     = bus.in_valid;
      assign rs_req     = in_req;
      assign rs_taken   = in_taken;
      assign rs_illegal = in_illegal;
    end
  endgenerate

  // Operands and predicted direction are consumed before the resolve stage.
  logic unused_rs;
  assign unused_rs = ^{rs_req.funct3, rs_req.rs1, rs_req.rs2, rs_req.pred_taken};

  bru_res_t rs_res;
  assign rs_res = bru_resolve(rs_req, rs_taken, rs_illegal);

  // Data only loads with a live entry, so a held result never changes under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_res <= '0;
    end else if (flush) begin
      out_vld <= 1'b0;
    end else if (adv) begin
      out_vld <= rs_vld;
      if (rs_vld) out_res <= rs_res;
    end
  end

  assign bus.out_valid       = out_vld;
  assign bus.out_taken       = out_res.taken;
  assign bus.out_target      = out_res.target;
  assign bus.out_mispredict  = out_res.mispredict;
  assign bus.out_redirect_pc = out_res.redirect_pc;
  assign bus.out_illegal     = out_res.illegal;

`ifdef BRU_PERF_CNT_EN
  // A flush on the same edge kills the output entry, so it is not counted.
  logic xfer;
  assign xfer = out_vld & bus.out_ready & !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_taken       <= '0;
      perf_mispredicts <= '0;
    end else if (xfer) begin
      if (perf_branches != '1) perf_branches <= perf_branches + 32'd1;
      if (out_res.taken && perf_taken != '1) perf_taken <= perf_taken + 32'd1;
      if (out_res.mispredict && perf_mispredicts != '1)
        perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  import bru_pkg::*;

  localparam int STAGES = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  bru_if #(.XLEN(32)) bus ();

  branch_resolve_unit #(.XLEN(32), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_out = 0;
  int cyc = 0;

  // Reference: queue of expected results in issue order, each with the number of
  // pipeline advances it has seen. An entry is visible once it has seen STAGES advances.
  bru_res_t exp_q[$];
  int       age_q[$];

  function automatic bru_res_t model(input logic [2:0] f3, input logic [31:0] a, b, pc,
                                     imm, pred);
    bru_res_t m;
    m = '0;
    m.target = pc + imm;
    case (f3)
      3'b000: m.taken = (a == b);
      3'b001: m.taken = (a != b);
      3'b100: m.taken = ($signed(a) < $signed(b));
      3'b101: m.taken = !($signed(a) < $signed(b));
      3'b110: m.taken = (a < b);
      3'b111: m.taken = !(a < b);
      default: m.illegal = 1'b1;
    endcase
    m.redirect_pc = m.taken ? m.target : pc + 32'd4;
    m.mispredict  = (m.redirect_pc != pred);
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic bit mvalid();
    return (exp_q.size() > 0) && (age_q[0] >= STAGES);
  endfunction

  task automatic set_in(input logic v, input logic [2:0] f3, input logic [31:0] a, b, pc,
                        imm, input logic pt, input logic [31:0] pred);
    bus.in_valid      = v;
    bus.in_funct3     = f3;
    bus.in_rs1        = a;
    bus.in_rs2        = b;
    bus.in_pc         = pc;
    bus.in_imm        = imm;
    bus.in_pred_taken = pt;
    bus.in_pred_pc    = pred;
  endtask

  task automatic idle();
    set_in(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  bit last_acc;

  task automatic tick();
    bit ev;
    bru_res_t m;
    #1;
    ev = mvalid();
    last_acc = 1'b0;
    chk("in_ready", bus.in_ready, (!ev || bus.out_ready));
    if (!rst_n || flush) begin
      exp_q.delete();
      age_q.delete();
    end else if (!ev || bus.out_ready) begin
      if (ev) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
        n_out++;
      end
      foreach (age_q[i]) age_q[i]++;
      if (bus.in_valid) begin
        exp_q.push_back(model(bus.in_funct3, bus.in_rs1, bus.in_rs2, bus.in_pc, bus.in_imm,
                              bus.in_pred_pc));
        age_q.push_back(1);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    ev = mvalid();
    chk("out_valid", bus.out_valid, ev);
    if (ev) begin
      m = exp_q[0];
      chk("out_taken", bus.out_taken, m.taken);
      chk("out_target", bus.out_target, m.target);
      chk("out_mispredict", bus.out_mispredict, m.mispredict);
      chk("out_redirect_pc", bus.out_redirect_pc, m.redirect_pc);
      chk("out_illegal", bus.out_illegal, m.illegal);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_taken"}, bus.out_taken, 0);
    chk({tag, "_target"}, bus.out_target, 0);
    chk({tag, "_mispredict"}, bus.out_mispredict, 0);
    chk({tag, "_redirect"}, bus.out_redirect_pc, 0);
    chk({tag, "_illegal"}, bus.out_illegal, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bru_res_t m;
    int taken_seen[$];
    int cyc_seen[$];
    int n0;
    bit saw_stall;
    logic [31:0] a, b, pc, imm, pred, r;
    logic [2:0] f3;

    idle();
    bus.out_ready = 1'b1;

    // Pin the reference model with hand-computed values.
    m = model(3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 32'h104);
    chk("model_beq_taken", m.taken, 1);
    chk("model_beq_target", m.target, 32'h120);
    chk("model_beq_mispredict", m.mispredict, 1);
    m = model(3'b100, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("model_blt_signed", m.taken, 1);
    m = model(3'b110, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("model_bltu_unsigned", m.taken, 0);
    m = model(3'b011, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h40, 32'h0);
    chk("model_ill_redirect", m.redirect_pc, 32'h0);
    chk("model_ill_flag", m.illegal, 1);

    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_zero("reset");
    chk("reset_in_ready", bus.in_ready, 1);

    // 1: BEQ latency and values
    set_in(1'b1, 3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b0, 32'h104);
    for (int i = 0; i < STAGES; i++) begin
      tick();
      idle();
    end
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_taken", bus.out_taken, 1);
    chk("t1_target", bus.out_target, 32'h120);
    chk("t1_redirect", bus.out_redirect_pc, 32'h120);
    chk("t1_mispredict", bus.out_mispredict, 1);
    repeat (3) tick();

    // 2: signed vs unsigned back-to-back
    for (int i = 0; i < 3; i++) begin
      f3 = (i == 0) ? 3'b100 : (i == 1) ? 3'b110 : 3'b111;
      set_in(1'b1, f3, 32'h8000_0000, 32'h0, 32'h200, 32'h10, 1'b0, 32'h204);
      tick();
      if (bus.out_valid) begin taken_seen.push_back(int'(bus.out_taken)); cyc_seen.push_back(cyc); end
    end
    idle();
    repeat (4) begin
      tick();
      if (bus.out_valid) begin taken_seen.push_back(int'(bus.out_taken)); cyc_seen.push_back(cyc); end
    end
    chk("t2_count", taken_seen.size(), 3);
    if (taken_seen.size() == 3) begin
      chk("t2_blt", taken_seen[0], 1);
      chk("t2_bltu", taken_seen[1], 0);
      chk("t2_bgeu", taken_seen[2], 1);
      chk("t2_b2b", cyc_seen[2] - cyc_seen[0], 2);
    end

    // 3: backpressure with 3 requests offered
    n0 = n_out;
    saw_stall = 1'b0;
    bus.out_ready = 1'b0;
    begin
      int k;
      k = 0;
      for (int c = 0; c < 12; c++) begin
        if (c == 3) bus.out_ready = 1'b1;
        if (k < 3) set_in(1'b1, 3'b001, 32'h10 + k, 32'h11, 32'h300 + 4 * k, 32'h8, 1'b1,
                          32'h308 + 4 * k);
        else idle();
        tick();
        if (last_acc) k++;
        if (!bus.out_ready && !bus.in_ready) saw_stall = 1'b1;
      end
    end
    idle();
    chk("t3_stall_seen", saw_stall, 1);
    chk("t3_delivered", n_out - n0, 3);

    // 4: flush with 2 in flight plus a simultaneous request
    n0 = n_out;
    bus.out_ready = 1'b0;
    set_in(1'b1, 3'b000, 32'h1, 32'h1, 32'h400, 32'h40, 1'b0, 32'h404);
    tick();
    set_in(1'b1, 3'b000, 32'h2, 32'h2, 32'h500, 32'h40, 1'b0, 32'h504);
    tick();
    set_in(1'b1, 3'b000, 32'h3, 32'h3, 32'h600, 32'h40, 1'b0, 32'h604);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("t4_valid_after_flush", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    chk("t4_none_delivered", n_out - n0, 0);

    // 5: illegal funct3 with wrapping fall-through, then mid-stream reset
    set_in(1'b1, 3'b011, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h100, 1'b0, 32'h0);
    for (int i = 0; i < STAGES; i++) begin
      tick();
      idle();
    end
    chk("t5_illegal", bus.out_illegal, 1);
    chk("t5_taken", bus.out_taken, 0);
    chk("t5_redirect", bus.out_redirect_pc, 32'h0);
    chk("t5_mispredict", bus.out_mispredict, 0);
    set_in(1'b1, 3'b101, 32'h9, 32'h3, 32'h700, 32'h20, 1'b1, 32'h720);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    chk_zero("t5_midreset");
    repeat (3) tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r = $urandom;
      a = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      imm = {{19{r[12]}}, r[12:1], 1'b0};
      pred = r[20] ? pc + imm : pc + 32'd4;
      f3 = 3'($urandom_range(0, 7));
      set_in($urandom_range(0, 3) != 0, f3, a, b, pc, imm, r[20], pred);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 39) == 0);
      tick();
      flush = 1'b0;
    end
    idle();
    bus.out_ready = 1'b1;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
